decryption_reg_master: RTL and testbench

Initiator for the decryption register-access interface (addr/read/write/wdata -> rdata/done/error). It takes one register command at a time from a valid/ready command port and issues a single-cycle read or write strobe on the bus. It then waits for done, with a timeout, and returns rdata and error status on a valid/ready response port. It sits between the host/config sequencer and the decryption register file.

---
 rtl/decryption_pkg.sv | 27 ++
 rtl/decryption_reg_master.sv | 107 ++++++++++
 tb/tb_decryption_reg_master.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decryption_pkg.sv
// Shared definitions for the decryption register-access interface:
// master FSM states and the register file address map with reset values.
package decryption_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [7:0] SELECT      = 8'h00;
   localparam logic [7:0] CAESAR_KEY  = 8'h10;
   localparam logic [7:0] SCYTALE_KEY = 8'h12;
   localparam logic [7:0] ZIGZAG_KEY  = 8'h14;

   localparam logic [15:0] SELECT_RST      = 16'h0000;
   localparam logic [15:0] CAESAR_KEY_RST  = 16'h0000;
   localparam logic [15:0] SCYTALE_KEY_RST = 16'hFFFF;
   localparam logic [15:0] ZIGZAG_KEY_RST  = 16'h0002;

   function automatic logic is_decoded(input logic [7:0] a);
      return (a == SELECT) || (a == CAESAR_KEY) ||
             (a == SCYTALE_KEY) || (a == ZIGZAG_KEY);
   endfunction

endpackage

// File: rtl/decryption_reg_master.sv
// Register-bus initiator: one command at a time from cmd_*, a single-cycle
// read/write strobe, a bounded wait for done, and the result on rsp_*.
module decryption_reg_master
   import decryption_pkg::*;
#(
   parameter int                    addr_width     = 8,
   parameter int                    reg_width      = 16,
   parameter int                    timeout_cycles = 15,
   parameter logic [addr_width-1:0] idle_addr      = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [addr_width-1:0] cmd_addr,
   input  logic [reg_width-1:0]  cmd_wdata,
   output logic [addr_width-1:0] addr,
   output logic                  read,
   output logic                  write,
   output logic [reg_width-1:0]  wdata,
   input  logic [reg_width-1:0]  rdata,
   input  logic                  done,
   input  logic                  error,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [reg_width-1:0]  rsp_rdata,
   output logic                  rsp_error,
   output logic                  rsp_timeout,
   output logic                  busy
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are
   // both 1; a valid response holds its fields stable until it is taken.
   localparam logic [7:0] TIMEOUT_CNT = 8'(timeout_cycles);

   state_t     state_q;
   logic [7:0] cnt_q;
   logic       is_write_q;

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);

   // Bus outputs are loaded on the handshake edge so the strobe is visible
   // for exactly the ISSUE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         addr        <= idle_addr;
         read        <= 1'b0;
         write       <= 1'b0;
         wdata       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
         cnt_q       <= '0;
         is_write_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  state_q    <= ISSUE;
                  addr       <= cmd_addr;
                  write      <= cmd_write;
                  read       <= !cmd_write;
                  wdata      <= cmd_write ? cmd_wdata : '0;
                  is_write_q <= cmd_write;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
               addr    <= idle_addr;
               read    <= 1'b0;
               write   <= 1'b0;
               wdata   <= '0;
               cnt_q   <= '0;
            end
            WAIT: begin
               cnt_q <= cnt_q + 8'd1;
               // done takes priority over a timeout landing on the same cycle
               if (done) begin
                  state_q     <= RESP;
                  rsp_valid   <= 1'b1;
                  rsp_error   <= error;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= (!is_write_q && !error) ? rdata : '0;
               end else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
                  state_q     <= RESP;
                  rsp_valid   <= 1'b1;
                  rsp_error   <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= '0;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q   <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decryption_reg_master.sv
// Directed bench for decryption_reg_master with an inline register-file
// responder that answers each strobe with done one cycle later.
module tb_decryption_reg_master;
   import decryption_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic [7:0]  addr;
   logic        read, write;
   logic [15:0] wdata, rdata;
   logic        done, error;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_error, rsp_timeout, busy;

   int checks = 0;
   int errors = 0;

   // responder state
   logic [15:0] r_select, r_caesar, r_scytale, r_zigzag;
   logic        r_done, r_err, inj_done, inj_err, mute;
   int          wr_seen, rd_seen;

   always #5 clk = ~clk;

   decryption_reg_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .addr(addr), .read(read), .write(write), .wdata(wdata),
      .rdata(rdata), .done(done), .error(error),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy)
   );

   assign done  = r_done | inj_done;
   assign error = r_err | inj_err;

   always @(posedge clk) begin
      if (rst) begin
         r_select  <= SELECT_RST;
         r_caesar  <= CAESAR_KEY_RST;
         r_scytale <= SCYTALE_KEY_RST;
         r_zigzag  <= ZIGZAG_KEY_RST;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         rdata     <= 16'h0;
         wr_seen   <= 0;
         rd_seen   <= 0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         rdata  <= 16'h0;
         if (write) wr_seen <= wr_seen + 1;
         if (read)  rd_seen <= rd_seen + 1;
         if (!mute && (read || write)) begin
            r_done <= 1'b1;
            case (addr)
               SELECT:      begin rdata <= r_select;  if (write) r_select  <= wdata; end
               CAESAR_KEY:  begin rdata <= r_caesar;  if (write) r_caesar  <= wdata; end
               SCYTALE_KEY: begin rdata <= r_scytale; if (write) r_scytale <= wdata; end
               ZIGZAG_KEY:  begin rdata <= r_zigzag;  if (write) r_zigzag  <= wdata; end
               default:     r_err <= 1'b1;
            endcase
         end
      end
   end

   // Driver: issue one command, capture the ISSUE-cycle bus view, the
   // response fields, and the cycle (ISSUE = 1) on which rsp_valid appears.
   task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [15:0] d,
                         output logic [15:0] o_rdata, output logic o_err,
                         output logic o_to, output int lat,
                         output logic [7:0] b_addr, output logic [15:0] b_wdata,
                         output logic b_rd, output logic b_wr);
      int n;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      b_addr = addr; b_wdata = wdata; b_rd = read; b_wr = write;
      lat = 1;
      while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      o_rdata = rsp_rdata; o_err = rsp_error; o_to = rsp_timeout;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_state busy=%b cmd_ready=%b exp 0/1", busy, cmd_ready);
      end
      checks++;
      if (addr !== 8'h00 || read !== 1'b0 || write !== 1'b0 || wdata !== 16'h0) begin
         errors++; $display("FAIL reset_bus addr=%h rd=%b wr=%b wdata=%h exp 00/0/0/0000", addr, read, write, wdata);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
         errors++; $display("FAIL reset_rsp valid=%b rdata=%h err=%b to=%b exp all 0", rsp_valid, rsp_rdata, rsp_error, rsp_timeout);
      end
   endtask

   task automatic test_reset_keys;
      logic [15:0] rd, bd; logic er, to, brd, bwr; logic [7:0] ba; int lat;
      do_cmd(1'b0, SCYTALE_KEY, 16'h0, rd, er, to, lat, ba, bd, brd, bwr);
      checks++;
      if (rd !== 16'hFFFF || er !== 1'b0 || to !== 1'b0) begin
         errors++; $display("FAIL scytale_reset_read rdata=%h err=%b to=%b exp ffff/0/0", rd, er, to);
      end
      do_cmd(1'b0, ZIGZAG_KEY, 16'h0, rd, er, to, lat, ba, bd, brd, bwr);
      checks++;
      if (rd !== 16'h0002 || er !== 1'b0) begin
         errors++; $display("FAIL zigzag_reset_read rdata=%h err=%b exp 0002/0", rd, er);
      end
   endtask

   task automatic test_write_read;
      logic [15:0] rd, bd; logic er, to, brd, bwr; logic [7:0] ba; int lat, w0, r0;
      w0 = wr_seen; r0 = rd_seen;
      do_cmd(1'b1, CAESAR_KEY, 16'h0003, rd, er, to, lat, ba, bd, brd, bwr);
      checks++;
      if (ba !== 8'h10 || bd !== 16'h0003 || bwr !== 1'b1 || brd !== 1'b0) begin
         errors++; $display("FAIL write_issue addr=%h wdata=%h wr=%b rd=%b exp 10/0003/1/0", ba, bd, bwr, brd);
      end
      checks++;
      if (rd !== 16'h0 || er !== 1'b0 || to !== 1'b0) begin
         errors++; $display("FAIL write_rsp rdata=%h err=%b to=%b exp 0000/0/0", rd, er, to);
      end
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL write_latency cycle=%0d exp 3", lat);
      end
      do_cmd(1'b0, CAESAR_KEY, 16'hBEEF, rd, er, to, lat, ba, bd, brd, bwr);
      checks++;
      if (ba !== 8'h10 || bd !== 16'h0 || brd !== 1'b1 || bwr !== 1'b0) begin
         errors++; $display("FAIL read_issue addr=%h wdata=%h rd=%b wr=%b exp 10/0000/1/0", ba, bd, brd, bwr);
      end
      checks++;
      if (rd !== 16'h0003 || er !== 1'b0 || to !== 1'b0) begin
         errors++; $display("FAIL read_rsp rdata=%h err=%b to=%b exp 0003/0/0", rd, er, to);
      end
      checks++;
      if (wr_seen - w0 !== 1 || rd_seen - r0 !== 1) begin
         errors++; $display("FAIL strobe_count writes=%0d reads=%0d exp 1/1", wr_seen - w0, rd_seen - r0);
      end
   endtask

   task automatic test_undecoded;
      logic [15:0] rd, bd; logic er, to, brd, bwr; logic [7:0] ba; int lat;
      do_cmd(1'b0, 8'h33, 16'h0, rd, er, to, lat, ba, bd, brd, bwr);
      checks++;
      if (rd !== 16'h0 || er !== 1'b1 || to !== 1'b0) begin
         errors++; $display("FAIL undecoded_rsp rdata=%h err=%b to=%b exp 0000/1/0", rd, er, to);
      end
      checks++;
      if (r_select !== 16'h0 || r_caesar !== 16'h0003 || r_scytale !== 16'hFFFF || r_zigzag !== 16'h0002) begin
         errors++; $display("FAIL undecoded_regs sel=%h cae=%h scy=%h zig=%h exp 0000/0003/ffff/0002",
                            r_select, r_caesar, r_scytale, r_zigzag);
      end
   endtask

   task automatic test_timeout;
      logic [15:0] rd, bd; logic er, to, brd, bwr; logic [7:0] ba; int lat;
      mute = 1'b1;
      do_cmd(1'b0, CAESAR_KEY, 16'h0, rd, er, to, lat, ba, bd, brd, bwr);
      mute = 1'b0;
      checks++;
      if (lat !== 17) begin
         errors++; $display("FAIL timeout_latency cycle=%0d exp 17", lat);
      end
      checks++;
      if (rd !== 16'h0 || er !== 1'b1 || to !== 1'b1) begin
         errors++; $display("FAIL timeout_rsp rdata=%h err=%b to=%b exp 0000/1/1", rd, er, to);
      end
   endtask

   task automatic test_backpressure;
      int n, bad;
      cmd_write = 1'b0; cmd_addr = SCYTALE_KEY; cmd_wdata = 16'h0; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_addr = ZIGZAG_KEY;
      n = 0;
      while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++; $display("FAIL bp_first_rsp valid=%b exp 1", rsp_valid);
      end
      bad = 0;
      repeat (10) begin
         if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hFFFF || rsp_error !== 1'b0 || cmd_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL bp_hold bad_cycles=%0d exp 0 (rdata=%h cmd_ready=%b)", bad, rsp_rdata, cmd_ready);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release cmd_ready=%b rsp_valid=%b exp 1/0", cmd_ready, rsp_valid);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (read !== 1'b1 || addr !== 8'h14) begin
         errors++; $display("FAIL bp_next_issue read=%b addr=%h exp 1/14", read, addr);
      end
      n = 0;
      while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0002) begin
         errors++; $display("FAIL bp_second_rsp valid=%b rdata=%h exp 1/0002", rsp_valid, rsp_rdata);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      int issues;
      cmd_write = 1'b0; cmd_addr = CAESAR_KEY; cmd_valid = 1'b1; rsp_ready = 1'b1;
      issues = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (read) issues++;
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (issues !== 4) begin
         errors++; $display("FAIL back_to_back strobes_in_16=%0d exp 4", issues);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] rd, bd; logic er, to, brd, bwr; logic [7:0] ba; int lat, stray;
      mute = 1'b1;
      cmd_write = 1'b0; cmd_addr = CAESAR_KEY; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mute = 1'b0;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || read !== 1'b0 || write !== 1'b0 || addr !== 8'h00) begin
         errors++; $display("FAIL mid_reset busy=%b rsp_valid=%b rd=%b wr=%b addr=%h exp 0/0/0/0/00",
                            busy, rsp_valid, read, write, addr);
      end
      do_cmd(1'b1, SELECT, 16'h0001, rd, er, to, lat, ba, bd, brd, bwr);
      checks++;
      if (lat !== 3 || er !== 1'b0 || to !== 1'b0 || rd !== 16'h0 || r_select !== 16'h0001) begin
         errors++; $display("FAIL post_reset_write cycle=%0d err=%b to=%b rdata=%h sel=%h exp 3/0/0/0000/0001",
                            lat, er, to, rd, r_select);
      end
      inj_done = 1'b1; inj_err = 1'b1;
      @(negedge clk);
      inj_done = 1'b0; inj_err = 1'b0;
      stray = 0;
      repeat (5) begin
         if (rsp_valid !== 1'b0 || busy !== 1'b0) stray++;
         @(negedge clk);
      end
      checks++;
      if (stray !== 0) begin
         errors++; $display("FAIL stray_done bad_cycles=%0d exp 0", stray);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 16'h0;
      rsp_ready = 1'b0; mute = 1'b0; inj_done = 1'b0; inj_err = 1'b0;
      test_reset();
      test_reset_keys();
      test_write_read();
      test_undecoded();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
